// File: rtl/kernel_run_pkg.sv
// Shared definitions for the kernel run controller: FSM states,
// result status encoding and the default run-cycle budget.
package kernel_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } run_state_t;

  typedef enum logic [1:0] {
    STATUS_OK      = 2'b00,
    STATUS_TIMEOUT = 2'b01,
    STATUS_STALE   = 2'b10
  } run_status_t;

  localparam logic [31:0] TIMEOUT_DEFAULT = 32'd1000000;

endpackage

// File: rtl/kernel_run_ctrl.sv
// Kernel run controller: launches one kernel run per request, times it,
// captures its return value (or a timeout / stale-finish status) and holds
// the result record until the consumer accepts it.
module kernel_run_ctrl
  import kernel_run_pkg::*;
#(
  parameter logic [31:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        launch_valid,
  output logic        launch_ready,
  output logic        k_reset,
  output logic        k_start,
  input  logic        k_finish,
  input  logic [31:0] k_return_val,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_value,
  output logic [31:0] res_cycles,
  output logic [1:0]  res_status,
  output logic        busy
);

  run_state_t  state;
  run_state_t  state_nx;
  logic [31:0] count;
  logic [31:0] count_nx;
  logic [31:0] res_value_nx;
  logic [31:0] res_cycles_nx;
  logic [1:0]  res_status_nx;

  // Next-state logic; the counter value equals the current RUN cycle index,
  // so a zero count with finish already high means the kernel never ran.
  always_comb begin
    state_nx      = state;
    count_nx      = count;
    res_value_nx  = res_value;
    res_cycles_nx = res_cycles;
    res_status_nx = res_status;
    case (state)
      ST_IDLE: begin
        if (launch_valid) begin
          state_nx = ST_RUN;
          count_nx = '0;
        end
      end
      ST_RUN: begin
        if (k_finish) begin
          state_nx = ST_DONE;
          if (count == '0) begin
            res_value_nx  = '0;
            res_cycles_nx = '0;
            res_status_nx = STATUS_STALE;
          end else begin
            res_value_nx  = k_return_val;
            res_cycles_nx = count;
            res_status_nx = STATUS_OK;
          end
        end else begin
          count_nx = count + 32'd1;
          if (count == TIMEOUT - 32'd1) begin
            state_nx      = ST_DONE;
            res_value_nx  = '0;
            res_cycles_nx = TIMEOUT;
            res_status_nx = STATUS_TIMEOUT;
          end
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State, counter and every output are registered; outputs are decoded
  // from the state being entered so they line up with that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      count        <= '0;
      launch_ready <= 1'b1;
      k_reset      <= 1'b1;
      k_start      <= 1'b0;
      busy         <= 1'b0;
      res_valid    <= 1'b0;
      res_value    <= '0;
      res_cycles   <= '0;
      res_status   <= STATUS_OK;
    end else begin
      state        <= state_nx;
      count        <= count_nx;
      launch_ready <= (state_nx == ST_IDLE);
      k_reset      <= (state_nx != ST_RUN);
      k_start      <= (state == ST_IDLE) && (state_nx == ST_RUN);
      busy         <= (state_nx == ST_RUN);
      res_valid    <= (state_nx == ST_DONE);
      res_value    <= res_value_nx;
      res_cycles   <= res_cycles_nx;
      res_status   <= res_status_nx;
    end
  end

endmodule
